// File: rtl/hd_out_pkg.sv
// Shared constants and state encodings for the hard-decision output path.
package hd_out_pkg;

    localparam int unsigned HDDW        = 32;
    localparam int unsigned KB          = 14;
    localparam int unsigned UNLOADCOUNT = 17;
    localparam int unsigned FRAMEWORDS  = KB * UNLOADCOUNT;
    localparam int unsigned CNTW        = 8;
    localparam int unsigned BUFDEPTH    = 8;
    localparam int unsigned BUFAW       = 3;
    localparam int unsigned FCNTW       = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } in_state_e;

endpackage

// File: rtl/hd_showahead_fifo.sv
// Small show-ahead FIFO: head entry is always visible on rd_data_c.
module hd_showahead_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full_c    = (count == PW'(DEPTH));
    assign empty_c   = (count == '0);
    assign rd_en     = pop & ~empty_c;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign wr_en     = push & (~full_c | rd_en);
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hd_frame_packer.sv
// Buffers the no-backpressure hard-decision stream and re-emits it as
// valid/ready with per-frame last tagging, overflow flag and frame counter.
module hd_frame_packer #(
    parameter int unsigned HDDW       = hd_out_pkg::HDDW,
    parameter int unsigned FRAMEWORDS = hd_out_pkg::FRAMEWORDS,
    parameter int unsigned CNTW       = hd_out_pkg::CNTW,
    parameter int unsigned BUFDEPTH   = hd_out_pkg::BUFDEPTH,
    parameter int unsigned BUFAW      = hd_out_pkg::BUFAW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            datavalid,
    input  logic [HDDW-1:0] HD_in,
    output logic [HDDW-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            frame_done,
    output logic            overflow,
    input  logic            ovf_clr,
    output logic [15:0]     frame_count
);

    import hd_out_pkg::*;

    localparam int unsigned EW = HDDW + 1;

    in_state_e       state;
    in_state_e       state_nxt;
    logic            in_frame;
    logic [CNTW-1:0] in_cnt;
    logic            cnt_last;
    logic            pop;
    logic            drop;
    logic            full;
    logic            empty;
    logic [EW-1:0]   rd_entry;

    assign cnt_last = (in_cnt == CNTW'(FRAMEWORDS - 1));
    assign m_valid  = ~empty;
    assign pop      = m_valid & m_ready;
    assign drop     = datavalid & full & ~pop;
    // Gate the raw head entry so an empty buffer presents zeros.
    assign m_data   = m_valid ? rd_entry[HDDW-1:0] : '0;
    assign m_last   = m_valid & rd_entry[HDDW];

    hd_showahead_fifo #(
        .W     (EW),
        .DEPTH (BUFDEPTH),
        .AW    (BUFAW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (datavalid),
        .pop       (pop),
        .wr_data   ({cnt_last, HD_in}),
        .rd_data_c (rd_entry),
        .full_c    (full),
        .empty_c   (empty)
    );

    // Framing counter advances on every input word, dropped or not.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt <= '0;
        end else if (datavalid) begin
            in_cnt <= cnt_last ? '0 : in_cnt + CNTW'(1);
        end
    end

    // Input tracking state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Input tracking next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (datavalid && in_cnt == '0) state_nxt = ACTIVE;
            ACTIVE:  if (datavalid && cnt_last)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input tracking output decode.
    always_comb begin
        in_frame = 1'b0;
        if (state == ACTIVE) begin
            in_frame = 1'b1;
        end
    end

    // Tracking state is informational and must agree with the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (in_frame == (in_cnt != '0));
        end
    end

    // Sticky overflow (set beats clear) and frame completion tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            frame_done <= pop & rd_entry[HDDW];
            if (pop && rd_entry[HDDW]) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hd_frame_packer.sv
// Self-checking bench for hd_frame_packer against a queue-based frame model.
module tb_hd_frame_packer;

    localparam int unsigned FW    = 238;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned VW    = 52;

    logic        clk;
    logic        rst;
    logic        datavalid;
    logic [31:0] HD_in;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        frame_done;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] frame_count;

    int checks;
    int failures;

    // Reference model: FIFO contents as {last, data}, plus framing and flags.
    logic [32:0]  mq [$];
    int unsigned  mcnt;
    bit           mfd;
    bit           movf;
    logic [15:0]  mfc;

    hd_frame_packer dut (
        .clk         (clk),
        .rst         (rst),
        .datavalid   (datavalid),
        .HD_in       (HD_in),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .frame_count (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VW-1:0] obs();
        return {m_valid, m_last, m_data, frame_done, overflow, frame_count};
    endfunction

    function automatic logic [VW-1:0] expv();
        bit          v;
        logic [32:0] h;
        v = (mq.size() != 0);
        h = v ? mq[0] : 33'd0;
        return {v, h[32], h[31:0], mfd, movf, mfc};
    endfunction

    function automatic void model_clear();
        mq.delete();
        mcnt = 0;
        mfd  = 1'b0;
        movf = 1'b0;
        mfc  = 16'd0;
    endfunction

    function automatic void model_step(input bit dv, input logic [31:0] d,
                                       input bit rdy, input bit clr);
        bit drop;
        drop = 1'b0;
        mfd  = 1'b0;
        if (rdy && mq.size() != 0) begin
            mfd = mq[0][32];
            void'(mq.pop_front());
        end
        if (mfd) mfc = mfc + 16'd1;
        if (dv) begin
            if (mq.size() < DEPTH) mq.push_back({(mcnt == FW - 1), d});
            else drop = 1'b1;
            mcnt = (mcnt + 1) % FW;
        end
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
    endfunction

    // One clock: drive at negedge, update model at posedge, return at negedge.
    task automatic cycle(input bit dv, input logic [31:0] d, input bit rdy, input bit clr);
        datavalid = dv;
        HD_in     = d;
        m_ready   = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_step(dv, d, rdy, clr);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        datavalid = 1'b0;
        HD_in     = '0;
        m_ready   = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs() !== expv() || obs() !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_stream();
        logic [31:0] last_seen;
        int          nlast;
        nlast = 0;
        last_seen = 32'hffff_ffff;
        for (int i = 0; i < FW + 3; i++) begin
            if (i < FW) cycle(1'b1, 32'(i), 1'b1, 1'b0);
            else        cycle(1'b0, '0, 1'b1, 1'b0);
            if (m_valid && m_last) begin
                nlast++;
                last_seen = m_data;
            end
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (nlast != 1 || last_seen !== 32'd237) begin
            failures++;
            $display("FAIL stream_last count=%0d data=%0d exp count=1 data=237", nlast, last_seen);
        end
        checks++;
        if (frame_count !== 16'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL stream_end fc=%0d ovf=%b exp fc=1 ovf=0", frame_count, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] last_seen;
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        checks++;
        if (dut.u_fifo.count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_fill count=%0d ovf=%b exp count=8 ovf=1", dut.u_fifo.count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(i) || obs() !== expv()) begin
                failures++;
                $display("FAIL ovf_drain idx=%0d got=%h exp=%h", i, obs(), expv());
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        last_seen = 32'hffff_ffff;
        for (int i = 9; i < FW + 3; i++) begin
            if (i < FW) cycle(1'b1, 32'(i), 1'b1, 1'b0);
            else        cycle(1'b0, '0, 1'b1, 1'b0);
            if (m_valid && m_last) last_seen = m_data;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL ovf_realign cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (last_seen !== 32'd237) begin
            failures++;
            $display("FAIL ovf_last_index got=%0d exp=237", last_seen);
        end
    endtask

    task automatic test_full_pushpop();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0);
            checks++;
            if (dut.u_fifo.count !== 4'd8 || obs() !== expv()) begin
                failures++;
                $display("FAIL full_pushpop cyc=%0d count=%0d got=%h exp=%h",
                         i, dut.u_fifo.count, obs(), expv());
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] d0;
        logic        l0;
        cycle(1'b1, 32'hdead_beef, 1'b0, 1'b0);
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        d0 = m_data;
        l0 = m_last;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, $urandom, 1'b0, 1'b0);
            checks++;
            if (m_valid !== 1'b1 || m_data !== d0 || m_last !== l0 || m_data !== 32'hdead_beef
                || obs() !== expv()) begin
                failures++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        drain(3);
    endtask

    task automatic test_reset_midframe();
        int          nout;
        int          last_at;
        nout = 0;
        last_at = -1;
        for (int i = 0; i < 100; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
        apply_reset();
        checks++;
        if (m_valid !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", obs(), expv());
        end
        for (int i = 0; i < FW + 3; i++) begin
            if (i < FW) cycle(1'b1, $urandom, 1'b1, 1'b0);
            else        cycle(1'b0, '0, 1'b1, 1'b0);
            if (m_valid) begin
                nout++;
                if (m_last) last_at = nout;
            end
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_stream cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (last_at != FW || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL reset_last at=%0d fc=%0d exp at=238 fc=1", last_at, frame_count);
        end
    endtask

    task automatic test_ovf_clr();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL clr_pre got=%b exp=1", overflow);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL clr_alone got=%b exp=0", overflow);
        end
        cycle(1'b1, $urandom, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1 || obs() !== expv()) begin
            failures++;
            $display("FAIL clr_with_drop got=%b exp=1", overflow);
        end
        drain(DEPTH + 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        test_reset();
        test_stream();
        test_overflow();
        test_full_pushpop();
        test_hold();
        test_reset_midframe();
        test_ovf_clr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
